wb_select_pipe: RTL and testbench

//  Parametrised register-writeback source selector with a registered output.

---
 rtl/wb_select_if.sv | 36 +++
 rtl/wb_select_pipe.sv | 163 ++++++++++++++++
 tb/tb_wb_select_pipe.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_select_if.sv
// ---------------------------------------------------------------------------
// wb_select_if
//   Handshake bundle between the writeback source selector and its neighbours.
//   The upstream side offers sel/src_data with in_valid and gets in_ready back.
//   The downstream side receives out_data/out_src/out_err with out_valid and
//   returns out_ready.
//
//   master : upstream + downstream environment (drives requests, out_ready)
//   slave  : wb_select_pipe (drives in_ready and the out_* result)
// ---------------------------------------------------------------------------
interface wb_select_if #(
    parameter int DATA_W  = 8,
    parameter int SRC_W   = 11,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) ();
    logic [NUM_SRC*SRC_W-1:0] src_data;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_src;
    logic                     out_err;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output src_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_err, out_valid
    );

    modport slave (
        input  src_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_src, out_err, out_valid
    );
endinterface

// File: rtl/wb_select_pipe.sv
// ---------------------------------------------------------------------------
// wb_select_pipe
//   Register-writeback source selector. Picks lane `sel` out of NUM_SRC
//   source lanes, narrows it from SRC_W to DATA_W and presents the result
//   through a 1-deep output register backed by a 1-deep skid register.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : synchronous, active-high
//     bus    : wb_select_if.slave
//                src_data/sel/in_valid -> in_ready    (upstream handshake)
//                out_data/out_src/out_err/out_valid <- out_ready (downstream)
//
//   Configuration
//     WB_SAT_EN defined   : lane is signed; out-of-range values clamp to the
//                           signed DATA_W limits and flag out_err.
//     WB_SAT_EN undefined : plain low-bit truncation; out_err = bad sel only.
//
//   in_ready is a register (= !skid valid), so out_ready never reaches
//   in_ready combinationally.
// ---------------------------------------------------------------------------
module wb_select_pipe #(
    parameter int DATA_W  = 8,
    parameter int SRC_W   = 11,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
) (
    input  logic           clk,
    input  logic           reset,
    wb_select_if.slave     bus
);

`ifdef WB_SAT_EN
    localparam logic signed [SRC_W-1:0] SAT_MAX = SRC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SRC_W-1:0] SAT_MIN = -SAT_MAX - SRC_W'(1);
`endif

    // Returns {err, data} for a selected lane.
    function automatic logic [DATA_W:0] narrow_sat(input logic signed [SRC_W-1:0] v);
`ifdef WB_SAT_EN
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[DATA_W-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[DATA_W-1:0]};
        else
            return {1'b0, v[DATA_W-1:0]};
`else
        return {1'b0, DATA_W'(v)};
`endif
    endfunction

    // ---- stage 0: lane select and narrowing (combinational) ----
    logic signed [SRC_W-1:0] lane_p0;
    logic                    sel_hit_p0;
    logic [DATA_W-1:0]       res_data_p0;
    logic                    res_err_p0;

    always_comb begin
        lane_p0    = '0;
        sel_hit_p0 = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                lane_p0    = bus.src_data[i*SRC_W +: SRC_W];
                sel_hit_p0 = 1'b1;
            end
        end
        {res_err_p0, res_data_p0} = narrow_sat(lane_p0);
        // A select past the last lane yields zero with the error flag set.
        if (!sel_hit_p0) begin
            res_err_p0  = 1'b1;
            res_data_p0 = '0;
        end
    end

    // ---- stage 1: output register + skid register ----
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [SEL_W-1:0]  src_p1;
    logic              err_p1;

    logic              skid_vld_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic [SEL_W-1:0]  skid_src_p1;
    logic              skid_err_p1;

    logic              rdy_p1;

    logic accept;
    logic load_main;
    logic take_skid;
    logic load_new;
    logic load_skid;
    logic vld_nxt;
    logic skid_vld_nxt;

    assign accept    = bus.in_valid & rdy_p1;
    assign load_main = !vld_p1 | bus.out_ready;

    always_comb begin
        take_skid    = 1'b0;
        load_new     = 1'b0;
        load_skid    = 1'b0;
        vld_nxt      = vld_p1;
        skid_vld_nxt = skid_vld_p1;
        if (load_main) begin
            if (skid_vld_p1) begin
                // Skid drains first so results leave in acceptance order.
                take_skid    = 1'b1;
                vld_nxt      = 1'b1;
                skid_vld_nxt = accept;
                load_skid    = accept;
            end else if (accept) begin
                load_new = 1'b1;
                vld_nxt  = 1'b1;
            end else begin
                vld_nxt = 1'b0;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            rdy_p1      <= 1'b0;
            data_p1     <= '0;
            src_p1      <= '0;
            err_p1      <= 1'b0;
        end else begin
            vld_p1      <= vld_nxt;
            skid_vld_p1 <= skid_vld_nxt;
            rdy_p1      <= !skid_vld_nxt;
            if (take_skid) begin
                data_p1 <= skid_data_p1;
                src_p1  <= skid_src_p1;
                err_p1  <= skid_err_p1;
            end else if (load_new) begin
                data_p1 <= res_data_p0;
                src_p1  <= bus.sel;
                err_p1  <= res_err_p0;
            end
        end
    end

    // Skid payload is only meaningful while skid_vld_p1 is set.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_data_p1 <= res_data_p0;
            skid_src_p1  <= bus.sel;
            skid_err_p1  <= res_err_p0;
        end
    end

    assign bus.in_ready  = rdy_p1;
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_src   = src_p1;
    assign bus.out_err   = err_p1;

endmodule

// File: tb/tb_wb_select_pipe.sv
// ---------------------------------------------------------------------------
// tb_wb_select_pipe
//   Scoreboard bench for wb_select_pipe with NUM_SRC=3 so that sel=3 is an
//   invalid select. Accepted requests are turned into expected results by a
//   behavioural model and queued; a separate monitor pops and compares on
//   every downstream transfer. Directed checks cover reset, latency, skid
//   ordering, bad select and the narrowing boundaries.
// ---------------------------------------------------------------------------
module tb_wb_select_pipe;
    localparam int DATA_W  = 8;
    localparam int SRC_W   = 11;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;
    localparam int EXP_W   = DATA_W + SEL_W + 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    wb_select_if #(.DATA_W(DATA_W), .SRC_W(SRC_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) bus ();

    wb_select_pipe #(.DATA_W(DATA_W), .SRC_W(SRC_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected {err, src, data} computed from the selection rules with integers.
    function automatic logic [EXP_W-1:0] model(input logic [NUM_SRC*SRC_W-1:0] src,
                                               input logic [SEL_W-1:0] s);
        int idx = int'(s);
        int lane;
        int v;
        int hi = (1 << (DATA_W - 1)) - 1;
        int lo = -(1 << (DATA_W - 1));
        logic [NUM_SRC*SRC_W-1:0] sh;
        if (idx >= NUM_SRC) return {1'b1, s, {DATA_W{1'b0}}};
        sh   = src >> (idx * SRC_W);
        lane = int'(sh[SRC_W-1:0]);
`ifdef WB_SAT_EN
        v = (lane >= (1 << (SRC_W - 1))) ? lane - (1 << SRC_W) : lane;
        if (v > hi) return {1'b1, s, DATA_W'(hi)};
        if (v < lo) return {1'b1, s, DATA_W'(lo)};
        return {1'b0, s, DATA_W'(v)};
`else
        v = lane % (1 << DATA_W);
        if (hi < lo) v = 0;
        return {1'b0, s, DATA_W'(v)};
`endif
    endfunction

    // Stimulus side of the scoreboard: record every accepted request.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.src_data, bus.sel));
            accepted++;
        end
    end

    // Monitor: compare every downstream transfer; also check output stability under stall.
    logic             prev_stall = 1'b0;
    logic [EXP_W-1:0] prev_out;
    always @(negedge clk) begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] want;
        got = {bus.out_err, bus.out_src, bus.out_data};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("stall_hold", 32'(got), 32'(prev_out));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'(got), 32'hFFFF_FFFF);
                end else begin
                    want = exp_q.pop_front();
                    chk("sb_result", 32'(got), 32'(want));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = got;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [SRC_W-1:0] val);
        bus.src_data[i*SRC_W +: SRC_W] = val;
    endtask

    initial begin
        logic [EXP_W-1:0] e;
        int cyc;
        bit did_reset;
        reset         = 1'b1;
        bus.src_data  = '0;
        bus.sel       = '0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;

        // Reset held three cycles with in_valid high.
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        end
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Single transfer, one-cycle latency.
        set_lane(1, 11'h0A5);
        bus.sel       = 2'd1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_data", 32'(bus.out_data), 32'hA5);
        chk("t2_src", 32'(bus.out_src), 32'd1);
        chk("t2_err", 32'(bus.out_err), 32'd0);
        step();
        chk("t2_idle", 32'(bus.out_valid), 32'd0);

        // Back-pressure fills main then skid; drains in order.
        bus.out_ready = 1'b0;
        set_lane(0, 11'h012);
        bus.sel      = 2'd0;
        bus.in_valid = 1'b1;
        step();
        set_lane(2, 11'h034);
        bus.sel = 2'd2;
        step();
        bus.in_valid = 1'b0;
        chk("t3_hold_data", 32'(bus.out_data), 32'h12);
        chk("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        chk("t3_second_valid", 32'(bus.out_valid), 32'd1);
        chk("t3_second_data", 32'(bus.out_data), 32'h34);
        chk("t3_second_src", 32'(bus.out_src), 32'd2);
        step();
        chk("t3_drained", 32'(bus.out_valid), 32'd0);
        chk("t3_in_ready", 32'(bus.in_ready), 32'd1);

        // Invalid select.
        bus.src_data = {$urandom, $urandom};
        bus.sel      = 2'd3;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("t4_data", 32'(bus.out_data), 32'd0);
        chk("t4_err", 32'(bus.out_err), 32'd1);
        chk("t4_src", 32'(bus.out_src), 32'd3);

        // Narrowing boundaries.
        set_lane(0, 11'h17F);
        bus.sel      = 2'd0;
        bus.in_valid = 1'b1;
        step();
        chk("t5_pos_data", 32'(bus.out_data), 32'h7F);
`ifdef WB_SAT_EN
        chk("t5_pos_err", 32'(bus.out_err), 32'd1);
`else
        chk("t5_pos_err", 32'(bus.out_err), 32'd0);
`endif
        set_lane(0, 11'h780);
        step();
        bus.in_valid = 1'b0;
        chk("t5_neg_data", 32'(bus.out_data), 32'h80);
        chk("t5_neg_err", 32'(bus.out_err), 32'd0);
        step();

        // Random traffic with one mid-stream reset.
        accepted  = 0;
        did_reset = 1'b0;
        cyc       = 0;
        while (accepted < 1000 && cyc < 20000) begin
            if (!did_reset && accepted >= 500) begin
                did_reset     = 1'b1;
                bus.out_ready = 1'b0;
                bus.in_valid  = 1'b1;
                repeat (3) step();
                chk("mid_busy", 32'(bus.out_valid), 32'd1);
                reset = 1'b1;
                step();
                chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
                reset = 1'b0;
                step();
                chk("mid_rst_release", 32'(bus.in_ready), 32'd1);
            end
            bus.src_data  = {$urandom, $urandom};
            bus.sel       = SEL_W'($urandom_range(0, 3));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            step();
            cyc++;
        end
        chk("random_accept_count", 32'(accepted >= 1000), 32'd1);

        // Drain and confirm nothing was left behind.
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("final_idle", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
